pwm_multi_channel: RTL and testbench

//   Multi-channel PWM generator, parametrised successor to the fixed-divisor clock divider.
//   One shared period counter, programmable period, independent duty per channel.

---
 rtl/pwm_multi_channel.sv | 168 ++++++++++++++++
 tb/tb_pwm_multi_channel.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty compare,
// and shadow registers so period/duty updates take effect only at period boundaries.
module pwm_multi_channel #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 28,
  parameter int unsigned RST_PERIOD = 5000,
  parameter int unsigned RST_DUTY   = 2500
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic                    update_pending
);

  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_act_period;
  logic [CNT_W-1:0]  r_sh_period;
  logic [CNT_W-1:0]  r_act_duty [NUM_CH];
  logic [CNT_W-1:0]  r_sh_duty  [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;
  logic              r_tick;
  logic              r_pend;

  logic [CNT_W-1:0]  w_duty_in [NUM_CH];
  logic [CNT_W-1:0]  w_period_clamped;
  logic [CNT_W-1:0]  w_cnt_cur;
  logic [CNT_W-1:0]  w_last;
  logic [NUM_CH-1:0] w_pwm_cmp;
  logic              w_wrap;

  logic              w_run;
  logic              w_cap_shadow;
  logic              w_cap_active;
  logic              w_apply_shadow;
  logic              w_pend_nxt;

  // Input unpacking and period clamp
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_duty_in[i] = duty_in[i*CNT_W +: CNT_W];
    end
    w_period_clamped = (period_in < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_in;
  end

  // The first RUN edge after IDLE always counts from zero
  always_comb begin
    w_cnt_cur = (r_state == S_RUN) ? r_cnt : '0;
    w_last    = r_act_period - CNT_W'(1);
    w_wrap    = (w_cnt_cur >= w_last);
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_pwm_cmp[i] = (w_cnt_cur < r_act_duty[i]);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = enable ? S_RUN : S_IDLE;
  end

  // Per-edge control: where loads land and when the shadow is promoted
  always_comb begin
    w_run          = 1'b0;
    w_cap_shadow   = 1'b0;
    w_cap_active   = 1'b0;
    w_apply_shadow = 1'b0;
    w_pend_nxt     = r_pend;
    case (w_state_nxt)
      S_IDLE: begin
        if (load) begin
          w_cap_shadow = 1'b1;
          w_cap_active = 1'b1;
        end else if (r_pend) begin
          w_apply_shadow = 1'b1;
        end
        w_pend_nxt = 1'b0;
      end
      S_RUN: begin
        w_run = 1'b1;
        if (load) begin
          w_cap_shadow = 1'b1;
          w_cap_active = w_wrap;
          w_pend_nxt   = ~w_wrap;
        end else if (w_wrap && r_pend) begin
          w_apply_shadow = 1'b1;
          w_pend_nxt     = 1'b0;
        end
      end
      default: begin
        w_run = 1'b0;
      end
    endcase
  end

  // Counter and registered outputs
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pwm  <= '0;
      r_tick <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_run) begin
        r_cnt  <= w_wrap ? '0 : (w_cnt_cur + CNT_W'(1));
        r_pwm  <= w_pwm_cmp;
        r_tick <= w_wrap;
      end else begin
        r_cnt  <= '0;
        r_pwm  <= '0;
        r_tick <= 1'b0;
      end
      r_pend <= w_pend_nxt;
    end
  end

  // Shadow and active period/duty registers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_act_period <= CNT_W'(RST_PERIOD);
      r_sh_period  <= CNT_W'(RST_PERIOD);
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_act_duty[i] <= CNT_W'(RST_DUTY);
        r_sh_duty[i]  <= CNT_W'(RST_DUTY);
      end
    end else begin
      if (w_cap_shadow) begin
        r_sh_period <= w_period_clamped;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          r_sh_duty[i] <= w_duty_in[i];
        end
      end
      if (w_cap_active) begin
        r_act_period <= w_period_clamped;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          r_act_duty[i] <= w_duty_in[i];
        end
      end else if (w_apply_shadow) begin
        r_act_period <= r_sh_period;
        for (int i = 0; i < int'(NUM_CH); i++) begin
          r_act_duty[i] <= r_sh_duty[i];
        end
      end
    end
  end

  assign pwm_out        = r_pwm;
  assign period_tick    = r_tick;
  assign update_pending = r_pend;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus random traffic,
// all compared against a period-position reference model.
module tb_pwm_multi_channel;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned CNT_W      = 28;
  localparam int unsigned RST_PERIOD = 5000;
  localparam int unsigned RST_DUTY   = 2500;

  logic                    clock_in = 1'b0;
  logic                    reset    = 1'b1;
  logic                    enable   = 1'b0;
  logic                    load     = 1'b0;
  logic [CNT_W-1:0]        period_in = '0;
  logic [NUM_CH*CNT_W-1:0] duty_in   = '0;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_tick;
  logic                    update_pending;

  int checks = 0;
  int errors = 0;

  pwm_multi_channel #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_PERIOD(RST_PERIOD), .RST_DUTY(RST_DUTY)
  ) dut (
    .clock_in(clock_in), .reset(reset), .enable(enable), .period_in(period_in),
    .duty_in(duty_in), .load(load), .pwm_out(pwm_out), .period_tick(period_tick),
    .update_pending(update_pending)
  );

  always #5 clock_in = ~clock_in;

  // Reference model: m_left = cycles still to run in the current period (0 = start fresh)
  int unsigned       m_per = RST_PERIOD, s_per = RST_PERIOD, m_left = 0;
  int unsigned       m_duty [NUM_CH];
  int unsigned       s_duty [NUM_CH];
  bit                m_pend = 1'b0;
  logic [NUM_CH-1:0] exp_pwm = '0;
  logic              exp_tick = 1'b0;

  function automatic int unsigned clamp_per(input int unsigned p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int unsigned m_cnt();
    return (m_left == 0) ? 0 : (m_per - m_left);
  endfunction

  always @(posedge clock_in or posedge reset) begin
    if (reset) begin
      m_per = RST_PERIOD; s_per = RST_PERIOD; m_left = 0; m_pend = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = RST_DUTY; s_duty[i] = RST_DUTY; end
      exp_pwm = '0; exp_tick = 1'b0;
    end else if (!enable) begin
      exp_pwm = '0; exp_tick = 1'b0; m_left = 0;
      if (load) begin
        s_per = clamp_per(int'(period_in)); m_per = s_per;
        for (int i = 0; i < NUM_CH; i++) begin
          s_duty[i] = int'(duty_in[i*CNT_W +: CNT_W]); m_duty[i] = s_duty[i];
        end
      end else if (m_pend) begin
        m_per = s_per; m_duty = s_duty;
      end
      m_pend = 1'b0;
    end else begin
      if (m_left == 0) m_left = m_per;
      for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = ((m_per - m_left) < m_duty[i]);
      exp_tick = (m_left == 1);
      if (load) begin
        s_per = clamp_per(int'(period_in));
        for (int i = 0; i < NUM_CH; i++) s_duty[i] = int'(duty_in[i*CNT_W +: CNT_W]);
        if (m_left == 1) begin m_per = s_per; m_duty = s_duty; m_pend = 1'b0; end
        else m_pend = 1'b1;
      end else if (m_left == 1 && m_pend) begin
        m_per = s_per; m_duty = s_duty; m_pend = 1'b0;
      end
      m_left = m_left - 1;
    end
  end

  task automatic set_inputs(input int unsigned per, input int unsigned d0, input int unsigned d1,
                            input int unsigned d2, input int unsigned d3);
    period_in = CNT_W'(per);
    duty_in   = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
  endtask

  // Load while idle, then stay idle one more edge; leaves the bench at a negedge
  task automatic idle_load(input int unsigned per, input int unsigned d0, input int unsigned d1,
                           input int unsigned d2, input int unsigned d3);
    @(negedge clock_in);
    enable = 1'b0; set_inputs(per, d0, d1, d2, d3); load = 1'b1;
    @(negedge clock_in);
    load = 1'b0;
    @(negedge clock_in);
  endtask

  // Advance until the counter holds the requested value; bench left at a negedge
  task automatic wait_cnt(input int unsigned target, input string tag);
    int n = 0;
    while (m_cnt() != target && n < 200) begin @(negedge clock_in); n++; end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL %s_wait: counter value %0d never reached %0d", tag, m_cnt(), target);
    end
  endtask

  task automatic test_reset();
    @(negedge clock_in);
    checks++;
    if ({pwm_out, period_tick, update_pending} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0", {pwm_out, period_tick, update_pending});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock_in);
    checks++;
    if ({pwm_out, period_tick, update_pending} !== '0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0", {pwm_out, period_tick, update_pending});
    end
  endtask

  task automatic test_duty_bounds();
    int hi [NUM_CH];
    int ticks = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    idle_load(10, 3, 0, 10, 15);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL t1_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
      ticks += int'(period_tick);
    end
    checks++;
    if (hi[0] != 6 || hi[1] != 0 || hi[2] != 20 || hi[3] != 20 || ticks != 2) begin
      errors++; $display("FAIL t1_counts: got hi=%0d/%0d/%0d/%0d ticks=%0d expected 6/0/20/20 ticks=2",
        hi[0], hi[1], hi[2], hi[3], ticks);
    end
  endtask

  task automatic test_midperiod_load();
    int hi = 0;
    idle_load(10, 3, 3, 3, 3);
    enable = 1'b1;
    wait_cnt(4, "t2");
    set_inputs(10, 7, 7, 7, 7); load = 1'b1;
    @(negedge clock_in);
    load = 1'b0;
    checks++;
    if (update_pending !== 1'b1) begin
      errors++; $display("FAIL t2_pending_set: got %b expected 1", update_pending);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL t2_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
      hi += int'(pwm_out[0]);
    end
    checks++;
    if (hi != 7 || update_pending !== 1'b0) begin
      errors++; $display("FAIL t2_apply: got hi=%0d pend=%b expected hi=7 pend=0", hi, update_pending);
    end
  endtask

  task automatic test_wrap_load();
    int hi = 0, ticks = 0, pend_seen = 0;
    idle_load(10, 3, 3, 3, 3);
    enable = 1'b1;
    wait_cnt(9, "t3");
    set_inputs(6, 2, 2, 2, 2); load = 1'b1;
    @(negedge clock_in);
    load = 1'b0;
    pend_seen += int'(update_pending);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL t3_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
      hi += int'(pwm_out[0]); ticks += int'(period_tick); pend_seen += int'(update_pending);
    end
    checks++;
    if (hi != 4 || ticks != 2 || pend_seen != 0) begin
      errors++; $display("FAIL t3_counts: got hi=%0d ticks=%0d pend=%0d expected 4/2/0", hi, ticks, pend_seen);
    end
  endtask

  task automatic test_period_clamp();
    int hi = 0, ticks = 0;
    idle_load(1, 1, 1, 1, 1);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL t4_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
      hi += int'(pwm_out[0]); ticks += int'(period_tick);
    end
    checks++;
    if (hi != 5 || ticks != 5) begin
      errors++; $display("FAIL t4_counts: got hi=%0d ticks=%0d expected 5/5", hi, ticks);
    end
  endtask

  task automatic test_enable_drop();
    int hi = 0, ticks = 0;
    idle_load(10, 3, 3, 3, 3);
    enable = 1'b1;
    wait_cnt(3, "t5");
    set_inputs(8, 5, 5, 5, 5); load = 1'b1;
    @(negedge clock_in);
    load = 1'b0;
    wait_cnt(5, "t5b");
    enable = 1'b0;
    @(negedge clock_in);
    checks++;
    if ({pwm_out, period_tick, update_pending} !== '0 || dut.r_cnt !== '0) begin
      errors++; $display("FAIL t5_drop: got outs=%b cnt=%0d expected 0/0",
        {pwm_out, period_tick, update_pending}, dut.r_cnt);
    end
    repeat (2) @(negedge clock_in);
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL t5_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
      hi += int'(pwm_out[0]); ticks += int'(period_tick);
    end
    checks++;
    if (hi != 10 || ticks != 2) begin
      errors++; $display("FAIL t5_counts: got hi=%0d ticks=%0d expected 10/2", hi, ticks);
    end
  endtask

  task automatic test_async_reset();
    int hi [NUM_CH];
    int ticks = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    idle_load(10, 10, 10, 10, 10);
    enable = 1'b1;
    wait_cnt(2, "t6");
    set_inputs(7, 1, 1, 1, 1); load = 1'b1;
    @(negedge clock_in);
    load = 1'b0;
    @(posedge clock_in);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pwm_out, period_tick, update_pending} !== '0) begin
      errors++; $display("FAIL t6_async: got %b expected 0", {pwm_out, period_tick, update_pending});
    end
    @(negedge clock_in);
    reset = 1'b0;
    for (int k = 0; k < int'(RST_PERIOD); k++) begin
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL t6_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
      ticks += int'(period_tick);
    end
    checks++;
    if (hi[0] != 2500 || hi[1] != 2500 || hi[2] != 2500 || hi[3] != 2500 || ticks != 1) begin
      errors++; $display("FAIL t6_defaults: got hi=%0d/%0d/%0d/%0d ticks=%0d expected 2500 each ticks=1",
        hi[0], hi[1], hi[2], hi[3], ticks);
    end
  endtask

  task automatic test_random();
    idle_load(12, 4, 0, 12, 7);
    for (int k = 0; k < 4000; k++) begin
      enable = ($urandom_range(0, 19) != 0);
      load   = ($urandom_range(0, 9) == 0);
      set_inputs($urandom_range(0, 20), $urandom_range(0, 24), $urandom_range(0, 24),
                 $urandom_range(0, 24), $urandom_range(0, 24));
      @(negedge clock_in);
      checks++;
      if ({pwm_out, period_tick, update_pending} !== {exp_pwm, exp_tick, m_pend}) begin
        errors++; $display("FAIL rand_cycle%0d: got %b expected %b", k,
          {pwm_out, period_tick, update_pending}, {exp_pwm, exp_tick, m_pend});
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_duty_bounds();
    test_midperiod_load();
    test_wrap_load();
    test_period_clamp();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
